// File: rtl/lifo_drain_ctrl.sv
// lifo_drain_ctrl: fills an external LIFO from a stream, then drains it in reverse order with a last marker
module lifo_drain_ctrl #(
  parameter int LIFO_SIZE    = 8,
  parameter int DATA_W       = 8,
  parameter int DRAIN_THRESH = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              flush,
  output logic              lifo_write,
  output logic              lifo_read,
  output logic [DATA_W-1:0] lifo_din,
  input  logic [DATA_W-1:0] lifo_dout,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic              busy,
  output logic [15:0]       burst_cnt
);
  localparam int OW = $clog2(LIFO_SIZE) + 1;
  typedef enum logic {FILL, DRAIN} state_t;
  state_t            state_q, state_d;
  logic [OW-1:0]     occ_q, occ_d;
  logic              rd_inflight_q, rd_last_q;
  logic [DATA_W-1:0] skid_data_q [2];
  logic              skid_last_q [2];
  logic              wr_ptr_q, rd_ptr_q;
  logic [1:0]        skid_cnt_q;
  logic [15:0]       burst_cnt_q;
  logic              pop, done, credit;
  assign lifo_din  = in_data;
  assign out_valid = skid_cnt_q != 2'd0;
  assign out_data  = skid_data_q[rd_ptr_q];
  assign out_last  = out_valid & skid_last_q[rd_ptr_q];
  assign busy      = state_q == DRAIN;
  assign burst_cnt = burst_cnt_q;
  assign pop       = out_valid & out_ready;
  assign done      = pop & out_last;
  // an item leaving the skid this cycle frees its slot for a read issued now
  assign credit    = 3'(skid_cnt_q) + 3'(rd_inflight_q) < 3'd2 + 3'(pop);
  // strobes, handshake and next state; lifo_write is held off while reset is asserted
  always_comb begin
    state_d    = state_q;
    in_ready   = 1'b0;
    lifo_write = 1'b0;
    lifo_read  = 1'b0;
    if (state_q == FILL) begin
      in_ready   = occ_q < OW'(LIFO_SIZE);
      lifo_write = in_valid & in_ready & ~reset;
      if ((lifo_write && occ_q == OW'(DRAIN_THRESH - 1)) || (flush && (occ_q != '0 || lifo_write)))
        state_d = DRAIN;
    end else begin
      lifo_read = occ_q != '0 && credit;
      state_d   = done ? FILL : DRAIN;
    end
    occ_d = lifo_write ? occ_q + 1'b1 : lifo_read ? occ_q - 1'b1 : occ_q;
  end
  // control state, read tracking and skid pointers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= FILL;
      occ_q         <= '0;
      rd_inflight_q <= 1'b0;
      rd_last_q     <= 1'b0;
      wr_ptr_q      <= 1'b0;
      rd_ptr_q      <= 1'b0;
      skid_cnt_q    <= 2'd0;
      burst_cnt_q   <= 16'd0;
    end else begin
      state_q       <= state_d;
      occ_q         <= occ_d;
      rd_inflight_q <= lifo_read;
      rd_last_q     <= lifo_read & (occ_q == OW'(1));
      wr_ptr_q      <= wr_ptr_q ^ rd_inflight_q;
      rd_ptr_q      <= rd_ptr_q ^ pop;
      skid_cnt_q    <= skid_cnt_q + 2'(rd_inflight_q) - 2'(pop);
      if (done) burst_cnt_q <= burst_cnt_q + 1'b1;
    end
  end
  // capture LIFO read data and its last tag the cycle after the read
  always_ff @(posedge clk) begin
    if (rd_inflight_q) begin
      skid_data_q[wr_ptr_q] <= lifo_dout;
      skid_last_q[wr_ptr_q] <= rd_last_q;
    end
  end
endmodule

// File: tb/tb_lifo_drain_ctrl.sv
// tb_lifo_drain_ctrl: directed checks of fill, threshold/flush drains, backpressure and reset
module tb_lifo_drain_ctrl;
  logic clk = 1'b0, reset = 1'b1;
  logic in_valid = 1'b0, flush = 1'b0, out_ready = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic in_ready, lifo_write, lifo_read, out_valid, out_last, busy;
  logic [7:0] lifo_din, lifo_dout, out_data;
  logic [15:0] burst_cnt;
  int checks = 0, errors = 0, cyc = 0, occ_m = 0, rd_cnt = 0, sp = 0;
  logic [7:0] mem [8];
  logic [7:0] got [$];
  logic got_last [$];
  int got_cyc [$];
  logic stall_q = 1'b0;
  logic [7:0] stall_d = 8'h00;

  lifo_drain_ctrl #(.LIFO_SIZE(8), .DATA_W(8), .DRAIN_THRESH(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .flush(flush), .lifo_write(lifo_write), .lifo_read(lifo_read), .lifo_din(lifo_din),
    .lifo_dout(lifo_dout), .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_ready(out_ready), .busy(busy), .burst_cnt(burst_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // external LIFO with registered read data
  always @(posedge clk or posedge reset) begin
    if (reset) sp <= 0;
    else if (lifo_write) begin
      if (sp < 8) mem[sp] <= lifo_din;
      sp <= sp + 1;
    end else if (lifo_read) begin
      lifo_dout <= (sp > 0 && sp <= 8) ? mem[sp-1] : 8'hxx;
      sp <= sp - 1;
    end
  end

  // per-cycle invariants and output collection
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      occ_m = 0;
      stall_q = 1'b0;
    end else begin
      chk("no_wr_rd", 32'(lifo_write & lifo_read), 0);
      chk("last_needs_valid", 32'(out_last & ~out_valid), 0);
      if (stall_q) begin
        chk("stall_valid", 32'(out_valid), 1);
        chk("stall_data", 32'(out_data), 32'(stall_d));
      end
      occ_m = occ_m + int'(lifo_write) - int'(lifo_read);
      chk("occ_range", 32'(occ_m >= 0 && occ_m <= 8), 1);
      if (lifo_read) rd_cnt++;
      if (out_valid & out_ready) begin
        got.push_back(out_data);
        got_last.push_back(out_last);
        got_cyc.push_back(cyc);
      end
      stall_q = out_valid & ~out_ready;
      stall_d = out_data;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear();
    got.delete();
    got_last.delete();
    got_cyc.delete();
    rd_cnt = 0;
  endtask

  task automatic push(input logic [7:0] d);
    in_valid = 1'b1;
    in_data = d;
    step();
    in_valid = 1'b0;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      step();
      n++;
    end
    chk(tag, 32'(busy), 0);
  endtask

  task automatic chk_burst(input string tag, input int n, input logic [7:0] base);
    chk({tag, "_count"}, got.size(), n);
    for (int i = 0; i < n && i < got.size(); i++) begin
      chk({tag, "_data"}, 32'(got[i]), 32'(base) + n - 1 - i);
      chk({tag, "_last"}, 32'(got_last[i]), 32'(i == n - 1));
    end
  endtask

  initial begin
    in_valid = 1'b1;
    in_data = 8'hff;
    step();
    step();
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_lifo_write", 32'(lifo_write), 0);
    chk("rst_lifo_read", 32'(lifo_read), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_last", 32'(out_last), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_burst_cnt", 32'(burst_cnt), 0);
    in_valid = 1'b0;
    reset = 1'b0;
    step();

    // threshold drain
    clear();
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_data = 8'(i);
      step();
    end
    in_valid = 1'b0;
    chk("s1_in_ready_low", 32'(in_ready), 0);
    chk("s1_busy", 32'(busy), 1);
    step();
    chk("s1_no_valid_yet", 32'(out_valid), 0);
    step();
    chk("s1_first_valid", 32'(out_valid), 1);
    chk("s1_first_data", 32'(out_data), 8'h08);
    wait_idle("s1_idle", 40);
    chk_burst("s1", 8, 8'h01);
    if (got.size() == 8) chk("s1_consecutive", 32'(got_cyc[7] - got_cyc[0]), 7);
    chk("s1_burst_cnt", 32'(burst_cnt), 1);
    step();
    chk("s1_in_ready_back", 32'(in_ready), 1);

    // flush partial
    clear();
    push(8'ha0);
    push(8'ha1);
    push(8'ha2);
    pulse_flush();
    chk("s2_busy", 32'(busy), 1);
    wait_idle("s2_idle", 40);
    chk_burst("s2", 3, 8'ha0);
    chk("s2_burst_cnt", 32'(burst_cnt), 2);
    // flush with empty LIFO is ignored
    clear();
    pulse_flush();
    step();
    step();
    step();
    chk("s2e_reads", rd_cnt, 0);
    chk("s2e_outputs", got.size(), 0);
    chk("s2e_busy", 32'(busy), 0);
    chk("s2e_burst_cnt", 32'(burst_cnt), 2);

    // backpressure during a threshold drain
    clear();
    for (int i = 0; i < 8; i++) push(8'h30 + 8'(i));
    begin
      int stall = 3;
      int n = 0;
      while (busy && n < 300) begin
        if (stall > 0) begin
          out_ready = 1'b0;
          stall--;
        end else begin
          out_ready = 1'b1;
          if ($urandom_range(0, 2) == 0) stall = $urandom_range(1, 5);
        end
        step();
        n++;
      end
    end
    out_ready = 1'b1;
    chk("s3_idle", 32'(busy), 0);
    chk_burst("s3", 8, 8'h30);
    chk("s3_reads", rd_cnt, 8);
    chk("s3_burst_cnt", 32'(burst_cnt), 3);

    // flush and push in the same cycle
    clear();
    push(8'h10);
    push(8'h11);
    in_valid = 1'b1;
    in_data = 8'h12;
    flush = 1'b1;
    step();
    in_valid = 1'b0;
    flush = 1'b0;
    chk("s4_busy", 32'(busy), 1);
    wait_idle("s4_idle", 40);
    chk_burst("s4", 3, 8'h10);
    chk("s4_burst_cnt", 32'(burst_cnt), 4);

    // reset in the middle of a burst
    clear();
    for (int i = 0; i < 8; i++) push(8'h40 + 8'(i));
    begin
      int n = 0;
      while (got.size() < 3 && n < 50) begin
        step();
        n++;
      end
    end
    chk("s5_three_out", got.size(), 3);
    reset = 1'b1;
    #1;
    chk("s5_out_valid", 32'(out_valid), 0);
    chk("s5_out_last", 32'(out_last), 0);
    chk("s5_busy", 32'(busy), 0);
    chk("s5_lifo_read", 32'(lifo_read), 0);
    chk("s5_in_ready", 32'(in_ready), 1);
    chk("s5_burst_cnt", 32'(burst_cnt), 0);
    step();
    reset = 1'b0;
    step();
    clear();
    push(8'h55);
    pulse_flush();
    wait_idle("s5_idle", 40);
    chk_burst("s5", 1, 8'h55);
    chk("s5_burst_after", 32'(burst_cnt), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
